// File: rtl/key_debouncer.sv
// Debounces one active-low pushbutton into a registered level plus press/release strobes.
// Optional press counter output is enabled by defining KEY_DEBOUNCE_PRESS_COUNT_EN.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse
`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 sample;

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        sample    = ~sync2_q;
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        // Any sample agreeing with the current level restarts the stability count.
        if (sample != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = sample;
                press_d   = sample;
                release_d = ~sample;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (press_d) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign press_count = count_q;
`endif

endmodule
